i2c_od_pio: RTL and testbench

Parametrised Avalon-MM open-drain PIO for bit-banged I2C and similar wired-AND buses. It supersedes single-bit output-only ports: WIDTH pins, each with a per-pin direction bit and a synchronised pin readback. It adds atomic set/clear writes, edge capture and a maskable level interrupt. It sits between the Nios II data master and top-level tristate pads, for example SCL and SDA.

---
 rtl/i2c_od_pio.sv | 123 ++++++++++++
 tb/tb_i2c_od_pio.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_od_pio.sv
// Open-drain PIO for bit-banged I2C style wired-AND buses.
// WIDTH pins, each with a direction bit, a synchronised readback path,
// edge capture and a maskable level interrupt. Avalon-MM slave with
// zero-wait writes and combinational, side-effect-free reads.
module i2c_od_pio #(
  parameter int unsigned          WIDTH       = 2,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '1,
  parameter logic [WIDTH-1:0]     DIR_RESET   = '1,
  parameter int unsigned          EDGE_TYPE   = 1,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] drive_low,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic [2:0] {
    REG_DATA     = 3'd0,
    REG_DIR      = 3'd1,
    REG_IRQMASK  = 3'd2,
    REG_EDGECAP  = 3'd3,
    REG_OUTSET   = 3'd4,
    REG_OUTCLEAR = 3'd5,
    REG_RSV6     = 3'd6,
    REG_RSV7     = 3'd7
  } reg_addr_e;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev_in;

  reg_addr_e        w_addr;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_sync_in;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_rd;
  logic             w_unused;

  assign w_addr    = reg_addr_e'(address);
  assign w_wr      = chipselect & ~write_n;
  assign w_wdata   = writedata[WIDTH-1:0];
  assign w_unused  = ^writedata;
  assign w_sync_in = r_sync[SYNC_STAGES-1];

  // Input synchroniser chain and previous-sample register; idle bus is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '{default: '1};
      r_prev_in <= '1;
    end else begin
      r_sync[0] <= pad_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev_in <= w_sync_in;
    end
  end

  // Edge event selection for the configured edge type.
  always_comb begin
    w_event = '0;
    case (EDGE_TYPE)
      0:       w_event = w_sync_in & ~r_prev_in;
      1:       w_event = ~w_sync_in & r_prev_in;
      default: w_event = w_sync_in ^ r_prev_in;
    endcase
  end

  assign w_w1c = (w_wr && w_addr == REG_EDGECAP) ? w_wdata : '0;

  // Register writes; a new edge event overrides a simultaneous W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= DIR_RESET;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_w1c) | w_event;
      if (w_wr) begin
        case (w_addr)
          REG_DATA:     r_data_out <= w_wdata;
          REG_DIR:      r_dir      <= w_wdata;
          REG_IRQMASK:  r_irqmask  <= w_wdata;
          REG_OUTSET:   r_data_out <= r_data_out | w_wdata;
          REG_OUTCLEAR: r_data_out <= r_data_out & ~w_wdata;
          default:      ;
        endcase
      end
    end
  end

  // Combinational read mux; DATA returns the real pin level, not data_out.
  always_comb begin
    w_rd = '0;
    case (w_addr)
      REG_DATA:    w_rd = w_sync_in;
      REG_DIR:     w_rd = r_dir;
      REG_IRQMASK: w_rd = r_irqmask;
      REG_EDGECAP: w_rd = r_edgecap;
      default:     w_rd = '0;
    endcase
  end

  assign readdata  = 32'(w_rd);
  assign drive_low = r_dir & ~r_data_out;
  assign out_port  = r_data_out;
  assign irq       = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_i2c_od_pio.sv
// Self-checking bench for i2c_od_pio: directed scenarios followed by
// randomized traffic, checked against a pin-history based reference model.
`timescale 1ns/1ns
module tb_i2c_od_pio;

  localparam int unsigned W  = 2;
  localparam int unsigned SS = 2;
  localparam int unsigned ET = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;
  logic [W-1:0]  pad_in;
  logic [W-1:0]  drive_low;
  logic [W-1:0]  out_port;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_data, m_dir, m_mask, m_edge, m_sync;
  logic [W-1:0] hist[$];

  i2c_od_pio #(
    .WIDTH(W),
    .RESET_VALUE(2'b11),
    .DIR_RESET(2'b11),
    .EDGE_TYPE(ET),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .pad_in(pad_in),
    .drive_low(drive_low),
    .out_port(out_port)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 2'b11;
    m_dir  = 2'b11;
    m_mask = '0;
    m_edge = '0;
    m_sync = '1;
    hist.delete();
    for (int i = 0; i < int'(SS) + 2; i++) hist.push_back('1);
  endtask

  // Pin history: hist[0] is the pad value sampled at the latest edge.
  task automatic model_edge();
    logic [W-1:0] old_sync, old_prev, ev, wd, w1c;
    if (!reset_n) return;
    hist.push_front(pad_in);
    void'(hist.pop_back());
    old_sync = hist[SS];
    old_prev = hist[SS+1];
    case (ET)
      0:       ev = old_sync & ~old_prev;
      1:       ev = ~old_sync & old_prev;
      default: ev = old_sync ^ old_prev;
    endcase
    wd  = writedata[W-1:0];
    w1c = '0;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_data = wd;
        3'd1: m_dir  = wd;
        3'd2: m_mask = wd;
        3'd3: w1c    = wd;
        3'd4: m_data = m_data | wd;
        3'd5: m_data = m_data & ~wd;
        default: ;
      endcase
    end
    m_edge = (m_edge & ~w1c) | ev;
    m_sync = hist[SS-1];
  endtask

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0: return 32'(m_sync);
      1: return 32'(m_dir);
      2: return 32'(m_mask);
      3: return 32'(m_edge);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_all();
    chipselect = 1'b0;
    write_n    = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("rd%0d", a), readdata, model_read(a));
    end
    chk("out_port",  32'(out_port),  32'(m_data));
    chk("drive_low", 32'(drive_low), 32'(m_dir & ~m_data));
    chk("irq",       32'(irq),       32'(|(m_edge & m_mask)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle();
    reset_n = 1'b1;
  endtask

  logic [31:0] v;

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    pad_in     = '1;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_all();
    chk("rst_out_port", 32'(out_port), 32'h3);
    chk("rst_drive_low", 32'(drive_low), 32'h0);
    rd(3'd1, v); chk("rst_dir", v, 32'h3);

    // Atomic clear/set of output bit 0
    wr(3'd5, 32'h1);
    chk("clr_drive_low", 32'(drive_low), 32'h1);
    chk("clr_out1", 32'(out_port[1]), 32'h1);
    wr(3'd4, 32'h1);
    chk("set_drive_low", 32'(drive_low), 32'h0);

    // Released pins, pin readback latency
    wr(3'd1, 32'h0);
    wr(3'd0, 32'h0);
    chk("dir0_drive_low", 32'(drive_low), 32'h0);
    pad_in = 2'b10;
    cycle();
    rd(3'd0, v); chk("sync_lat1", v, 32'h3);
    cycle();
    rd(3'd0, v); chk("sync_lat2", v, 32'h2);
    wr(3'd1, 32'h3);
    wr(3'd0, 32'h3);
    pad_in = 2'b11;
    repeat (3) cycle();

    // Falling edge on bit 1 captured and raising irq
    wr(3'd2, 32'h2);
    pad_in = 2'b01;
    cycle();
    cycle();
    chk("edge_early_irq", 32'(irq), 32'h0);
    cycle();
    rd(3'd3, v); chk("edge_cap", v & 32'h2, 32'h2);
    chk("edge_irq", 32'(irq), 32'h1);
    wr(3'd3, 32'h2);
    chk("w1c_irq", 32'(irq), 32'h0);

    // New edge coinciding with W1C of the same bit
    pad_in = 2'b11;
    repeat (3) cycle();
    pad_in = 2'b01;
    cycle();
    cycle();
    wr(3'd3, 32'h2);
    rd(3'd3, v); chk("coinc_cap", v & 32'h2, 32'h2);
    chk("coinc_irq", 32'(irq), 32'h1);
    wr(3'd3, 32'h3);
    chk("clear_irq", 32'(irq), 32'h0);

    // Clock stretching: bit 0 released but held low externally
    pad_in = 2'b10;
    repeat (2) cycle();
    chk("stretch_out0", 32'(out_port[0]), 32'h1);
    rd(3'd0, v); chk("stretch_rd0", v & 32'h1, 32'h0);
    wr(3'd2, 32'h3);
    repeat (2) cycle();
    do_reset();
    chk("rst_mid_irq", 32'(irq), 32'h0);
    chk("rst_mid_out", 32'(out_port), 32'h3);
    pad_in = 2'b11;
    repeat (3) cycle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) pad_in = W'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        address    = 3'($urandom_range(0, 7));
        writedata  = $urandom;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end else begin
        address    = 3'($urandom_range(0, 7));
        writedata  = $urandom;
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'b1;
      end
      cycle();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
